pipeline_ctrl: RTL

Central pipeline sequencer for the five-stage ARM-subset core. It decides each cycle whether the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, freeze or take a bubble. The decision draws on three inputs: memory-stall handshakes, taken branches resolved in EXE, and RAW data hazards detected against ID-stage sources. It also tracks memory-wait timeouts and keeps saturating stall and flush counters for bring-up.

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 43 ++++
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: FSM states, register-number width
// and the bundle of freeze/flush controls driven to the pipeline registers.
package pipeline_ctrl_pkg;

   localparam int REG_W = 4;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_freeze;
      logic if_id_freeze;
      logic id_ex_freeze;
      logic ex_mem_freeze;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_bubble;
   } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard check of the ID-stage sources against the EXE and
// MEM destinations; with forwarding on, only a load-use in EXE forces a stall.
module hazard_detect
   import pipeline_ctrl_pkg::*;
(
   input  logic             id_valid,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             forward_en,
   output logic             hazard
);

   logic m1;
   logic m2;

   function automatic logic src_match(input logic [REG_W-1:0] src,
                                      input logic [REG_W-1:0] e_dest,
                                      input logic e_wb,
                                      input logic e_load,
                                      input logic [REG_W-1:0] m_dest,
                                      input logic m_wb,
                                      input logic fwd);
      logic hit;
      if (fwd)
         hit = e_load & e_wb & (e_dest == src);
      else
         hit = (e_wb & (e_dest == src)) | (m_wb & (m_dest == src));
      return hit;
   endfunction

   always_comb begin
      m1     = src_match(src1, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, forward_en);
      m2     = src_match(src2, exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en, forward_en);
      hazard = id_valid & (m1 | (two_src & m2));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle freeze/flush decisions for the five-stage core,
// memory-wait timeout FSM and saturating stall/flush counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] src1,
   input  logic [REG_W-1:0] src2,
   input  logic             two_src,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             forward_en,
   input  logic             branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   output logic             pc_freeze,
   output logic             if_id_freeze,
   output logic             id_ex_freeze,
   output logic             ex_mem_freeze,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_wb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic  hazard;
   logic  mstall;
   logic  flush_ev;
   logic  stall_ev;
   ctrl_t ctrl;

   hazard_detect u_hazard (
      .id_valid     (id_valid),
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .forward_en   (forward_en),
      .hazard       (hazard)
   );

   // ERROR keeps the whole pipe frozen until reset.
   assign mstall = (state_q == ERROR) | (mem_access & ~mem_ready);

   always_comb begin
      ctrl = '0;
      if (rst) begin
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
      end else if (mstall) begin
         ctrl.pc_freeze     = 1'b1;
         ctrl.if_id_freeze  = 1'b1;
         ctrl.id_ex_freeze  = 1'b1;
         ctrl.ex_mem_freeze = 1'b1;
         ctrl.mem_wb_bubble = 1'b1;
      end else if (branch_taken) begin
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
      end else if (hazard) begin
         ctrl.pc_freeze    = 1'b1;
         ctrl.if_id_freeze = 1'b1;
         ctrl.id_ex_flush  = 1'b1;
      end
   end

   assign stall_ev = ~rst & (mstall | hazard);
   assign flush_ev = ~rst & ~mstall & branch_taken;

   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      case (state_q)
         RUN: begin
            if (mstall)
               state_d = MEM_WAIT;
         end
         MEM_WAIT: begin
            // A ready on the last count cycle releases rather than times out.
            if (!mstall)
               state_d = RUN;
            else if (wait_q == WAIT_LAST)
               state_d = ERROR;
            else
               wait_d = wait_q + 1'b1;
         end
         ERROR: state_d = ERROR;
         default: state_d = RUN;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall_ev && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;

      flush_cnt_d = flush_cnt_q;
      if (flush_ev && (flush_cnt_q != {CNT_W{1'b1}}))
         flush_cnt_d = flush_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wait_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_freeze     = ctrl.pc_freeze;
   assign if_id_freeze  = ctrl.if_id_freeze;
   assign id_ex_freeze  = ctrl.id_ex_freeze;
   assign ex_mem_freeze = ctrl.ex_mem_freeze;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_flush   = ctrl.id_ex_flush;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;
   assign mem_err       = (state_q == ERROR);
   assign stall_cnt     = stall_cnt_q;
   assign flush_cnt     = flush_cnt_q;

endmodule
